dream_replay_scheduler: RTL

Sequences STDP memory replay into the SNN fabric during sleep. While the circadian clock holds `sleep_mode` and pulses `dream_active`, the block grants fixed-length replay bursts to NUM_REQ memory-region requesters. Arbitration is round-robin. The block streams replay addresses to the fabric over a valid/ready handshake and asserts `stdp_enable` only while a burst is in flight. It sits between the circadian controller outputs, the hippocampal replay buffers (requesters) and the SNN fabric STDP port.

---
 rtl/dream_replay_scheduler.sv | 165 ++++++++++++++++
 1 files changed

// File: rtl/dream_replay_scheduler.sv
// dream_replay_scheduler
// Grants fixed-length STDP replay bursts to memory-region requesters in
// round-robin order while the circadian sleep/REM window is open, and streams
// the replay addresses to the SNN fabric over a valid/ready handshake.
module dream_replay_scheduler #(
  parameter int NUM_REQ    = 4,
  parameter int BURST_LEN  = 16,
  parameter int ADDR_W     = 16,
  parameter int GAP_CYCLES = 64
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      sleep_mode,
  input  logic                      dream_active,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0] req_base_addr,
  output logic [NUM_REQ-1:0]        req_grant,
  output logic                      replay_valid,
  input  logic                      replay_ready,
  output logic [ADDR_W-1:0]         replay_addr,
  output logic [2:0]                replay_src,
  output logic                      replay_last,
  output logic                      stdp_enable,
  output logic                      burst_done,
  output logic [15:0]               bursts_completed,
  output logic [7:0]                abort_count
);

  localparam int PTR_W  = $clog2(NUM_REQ);
  localparam int BEAT_W = $clog2(BURST_LEN);
  localparam int GAP_W  = $clog2(GAP_CYCLES + 1);

  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BURST_LEN - 1);
  localparam logic [GAP_W-1:0]  GAP_END   = GAP_W'(GAP_CYCLES - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARB   = 2'd1;
  localparam logic [1:0] S_BURST = 2'd2;
  localparam logic [1:0] S_GAP   = 2'd3;

  logic [1:0]        state;
  logic [PTR_W-1:0]  rr_ptr;
  logic [BEAT_W-1:0] beat;
  logic [GAP_W-1:0]  gap_cnt;
  logic              abort_pend;

  logic              win;
  logic              handshake;
  logic              found;
  logic [PTR_W-1:0]  cand;
  logic [PTR_W-1:0]  pick;
  logic [PTR_W-1:0]  pick_next;
  logic [ADDR_W-1:0] pick_base;
  logic [NUM_REQ-1:0] pick_onehot;

  assign win       = sleep_mode & dream_active;
  assign handshake = replay_valid & replay_ready;

  // Round-robin pick: first valid requester at or above rr_ptr, wrapping around
  always_comb begin
    found       = 1'b0;
    cand        = '0;
    pick        = '0;
    pick_base   = '0;
    pick_onehot = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((int'(rr_ptr) + k) % NUM_REQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
    pick_next = PTR_W'((int'(pick) + 1) % NUM_REQ);
    for (int i = 0; i < NUM_REQ; i++) begin
      if (pick == PTR_W'(i)) begin
        pick_base      = req_base_addr[i*ADDR_W +: ADDR_W];
        pick_onehot[i] = 1'b1;
      end
    end
  end

  // Sequencer: window tracking, burst beats, inter-burst gap and counters.
  // A beat is always presented during BURST, so an abort always waits for the
  // current beat to be accepted; abort_pend remembers a window drop seen while
  // the beat was stalled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state            <= S_IDLE;
      rr_ptr           <= '0;
      beat             <= '0;
      gap_cnt          <= '0;
      abort_pend       <= 1'b0;
      req_grant        <= '0;
      replay_valid     <= 1'b0;
      replay_addr      <= '0;
      replay_src       <= '0;
      replay_last      <= 1'b0;
      stdp_enable      <= 1'b0;
      burst_done       <= 1'b0;
      bursts_completed <= '0;
      abort_count      <= '0;
    end else begin
      burst_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (win) state <= S_ARB;
        end
        S_ARB: begin
          if (!win) begin
            state <= S_IDLE;
          end else if (found) begin
            state        <= S_BURST;
            rr_ptr       <= pick_next;
            req_grant    <= pick_onehot;
            replay_src   <= 3'(pick);
            replay_addr  <= pick_base;
            replay_valid <= 1'b1;
            replay_last  <= 1'b0;
            stdp_enable  <= 1'b1;
            beat         <= '0;
            abort_pend   <= 1'b0;
          end
        end
        S_BURST: begin
          if (handshake) begin
            if (beat == LAST_BEAT) begin
              state        <= S_GAP;
              gap_cnt      <= '0;
              burst_done   <= 1'b1;
              req_grant    <= '0;
              replay_valid <= 1'b0;
              replay_last  <= 1'b0;
              stdp_enable  <= 1'b0;
              if (bursts_completed != 16'hFFFF) bursts_completed <= bursts_completed + 16'd1;
            end else if (!win || abort_pend) begin
              state        <= S_IDLE;
              req_grant    <= '0;
              replay_valid <= 1'b0;
              replay_last  <= 1'b0;
              stdp_enable  <= 1'b0;
              if (abort_count != 8'hFF) abort_count <= abort_count + 8'd1;
            end else begin
              beat        <= beat + 1'b1;
              replay_addr <= replay_addr + 1'b1;
              replay_last <= ((beat + 1'b1) == LAST_BEAT);
            end
          end else if (!win) begin
            abort_pend <= 1'b1;
          end
        end
        S_GAP: begin
          if (!win) begin
            state <= S_IDLE;
          end else if (gap_cnt == GAP_END) begin
            state <= S_ARB;
          end else begin
            gap_cnt <= gap_cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
